// File: rtl/ub_read_sequencer.sv
// ub_read_sequencer: issues unified-buffer read addresses for one matrix and streams it onto two lanes.
// Optional macro UB_RD_SKEW_EN: lane 1 runs one cycle behind lane 0 through an extra register stage.
module ub_read_sequencer #(
   parameter int UB_DEPTH = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_start_in,
   input  logic        rd_transpose_in,
   input  logic [8:0]  rd_ptr_select_in,
   input  logic [15:0] rd_addr_in,
   input  logic [15:0] rd_row_size_in,
   input  logic [15:0] rd_col_size_in,
   output logic        mem_rd_en,
   output logic [15:0] mem_rd_addr_0,
   output logic [15:0] mem_rd_addr_1,
   input  logic [15:0] mem_rd_data_0,
   input  logic [15:0] mem_rd_data_1,
   output logic [15:0] lane_data_out_0,
   output logic [15:0] lane_data_out_1,
   output logic        lane_valid_out_0,
   output logic        lane_valid_out_1,
   output logic [2:0]  rd_dest_out,
   output logic [15:0] col_size_out,
   output logic        col_size_valid_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

   localparam logic [15:0] ADDR_MASK = 16'(UB_DEPTH - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] acc0_q, acc0_d;
   logic [15:0] acc1_q, acc1_d;
   logic [15:0] stride_q, stride_d;
   logic [15:0] nsize_q, nsize_d;
   logic [2:0]  dest_q, dest_d;
   logic        two_lane_q, two_lane_d;
   logic        csv_q, csv_d;
   logic        err_q, err_d;
   logic        rd_pend_q, rd_pend_d;
   logic        l0_valid_q, l0_valid_d;
   logic [15:0] l0_data_q, l0_data_d;
   logic        l1_valid_q, l1_valid_d;
   logic [15:0] l1_data_q, l1_data_d;

   logic [15:0] n_steps;
   logic [15:0] other_dim;
   logic [15:0] drain_last;
   logic        cmd_ok;
   logic        accept;
   logic        cap1;

   assign n_steps   = rd_transpose_in ? rd_col_size_in : rd_row_size_in;
   assign other_dim = rd_transpose_in ? rd_row_size_in : rd_col_size_in;
   assign cmd_ok    = (n_steps != 16'd0) && (other_dim != 16'd0) && (other_dim <= 16'd2)
                      && (rd_ptr_select_in <= 9'd4);
   assign accept    = rd_start_in && cmd_ok && (state_q == ST_IDLE);
   assign cap1      = rd_pend_q && two_lane_q;

   // Drain counter end value: lane 0 finishes two cycles after the last issue, skewed lane 1 one later.
`ifdef UB_RD_SKEW_EN
   assign drain_last = two_lane_q ? 16'd2 : 16'd1;
`else
   assign drain_last = 16'd1;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc0_d     = acc0_q;
      acc1_d     = acc1_q;
      stride_d   = stride_q;
      nsize_d    = nsize_q;
      dest_d     = dest_q;
      two_lane_d = two_lane_q;
      csv_d      = accept;
      err_d      = rd_start_in && !accept;
      rd_pend_d  = (state_q == ST_ISSUE);
      l0_valid_d = rd_pend_q;
      l0_data_d  = rd_pend_q ? mem_rd_data_0 : l0_data_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_ISSUE;
               cnt_d      = n_steps - 16'd1;
               acc0_d     = rd_addr_in;
               // Lane 1 starts one column over (normal) or one row down (transpose).
               acc1_d     = rd_transpose_in ? (rd_addr_in + rd_col_size_in) : (rd_addr_in + 16'd1);
               stride_d   = rd_transpose_in ? 16'd1 : rd_col_size_in;
               nsize_d    = n_steps;
               dest_d     = rd_ptr_select_in[2:0];
               two_lane_d = (other_dim == 16'd2);
            end
         end
         ST_ISSUE: begin
            acc0_d = acc0_q + stride_q;
            acc1_d = acc1_q + stride_q;
            if (cnt_q == 16'd0) begin
               state_d = ST_DRAIN;
               cnt_d   = drain_last;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef UB_RD_SKEW_EN
   logic        sk_valid_q, sk_valid_d;
   logic [15:0] sk_data_q, sk_data_d;

   always_comb begin
      sk_valid_d = cap1;
      sk_data_d  = cap1 ? mem_rd_data_1 : (two_lane_d ? sk_data_q : 16'd0);
      l1_valid_d = sk_valid_q;
      l1_data_d  = sk_valid_q ? sk_data_q : (two_lane_d ? l1_data_q : 16'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_valid_q <= 1'b0;
         sk_data_q  <= 16'd0;
      end else begin
         sk_valid_q <= sk_valid_d;
         sk_data_q  <= sk_data_d;
      end
   end
`else
   always_comb begin
      l1_valid_d = cap1;
      l1_data_d  = cap1 ? mem_rd_data_1 : (two_lane_d ? l1_data_q : 16'd0);
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 16'd0;
         acc0_q     <= 16'd0;
         acc1_q     <= 16'd0;
         stride_q   <= 16'd0;
         nsize_q    <= 16'd0;
         dest_q     <= 3'd0;
         two_lane_q <= 1'b0;
         csv_q      <= 1'b0;
         err_q      <= 1'b0;
         rd_pend_q  <= 1'b0;
         l0_valid_q <= 1'b0;
         l0_data_q  <= 16'd0;
         l1_valid_q <= 1'b0;
         l1_data_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc0_q     <= acc0_d;
         acc1_q     <= acc1_d;
         stride_q   <= stride_d;
         nsize_q    <= nsize_d;
         dest_q     <= dest_d;
         two_lane_q <= two_lane_d;
         csv_q      <= csv_d;
         err_q      <= err_d;
         rd_pend_q  <= rd_pend_d;
         l0_valid_q <= l0_valid_d;
         l0_data_q  <= l0_data_d;
         l1_valid_q <= l1_valid_d;
         l1_data_q  <= l1_data_d;
      end
   end

   assign mem_rd_en          = (state_q == ST_ISSUE);
   assign mem_rd_addr_0      = acc0_q & ADDR_MASK;
   assign mem_rd_addr_1      = acc1_q & ADDR_MASK;
   assign lane_data_out_0    = l0_data_q;
   assign lane_data_out_1    = l1_data_q;
   assign lane_valid_out_0   = l0_valid_q;
   assign lane_valid_out_1   = l1_valid_q;
   assign rd_dest_out        = dest_q;
   assign col_size_out       = nsize_q;
   assign col_size_valid_out = csv_q;
   assign busy               = (state_q != ST_IDLE);
   assign done               = (state_q == ST_DONE);
   assign err                = err_q;

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Scoreboard bench for ub_read_sequencer: directed scenarios then random instructions against an element-level model.
module tb_ub_read_sequencer;

`ifdef UB_RD_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif

   typedef struct {
      int cyc;
      int a;
      int b;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_start_in;
   logic        rd_transpose_in;
   logic [8:0]  rd_ptr_select_in;
   logic [15:0] rd_addr_in;
   logic [15:0] rd_row_size_in;
   logic [15:0] rd_col_size_in;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr_0;
   logic [15:0] mem_rd_addr_1;
   logic [15:0] mem_rd_data_0;
   logic [15:0] mem_rd_data_1;
   logic [15:0] lane_data_out_0;
   logic [15:0] lane_data_out_1;
   logic        lane_valid_out_0;
   logic        lane_valid_out_1;
   logic [2:0]  rd_dest_out;
   logic [15:0] col_size_out;
   logic        col_size_valid_out;
   logic        busy;
   logic        done;
   logic        err;

   ub_read_sequencer #(.UB_DEPTH(128)) dut (
      .clk                (clk),
      .rst                (rst),
      .rd_start_in        (rd_start_in),
      .rd_transpose_in    (rd_transpose_in),
      .rd_ptr_select_in   (rd_ptr_select_in),
      .rd_addr_in         (rd_addr_in),
      .rd_row_size_in     (rd_row_size_in),
      .rd_col_size_in     (rd_col_size_in),
      .mem_rd_en          (mem_rd_en),
      .mem_rd_addr_0      (mem_rd_addr_0),
      .mem_rd_addr_1      (mem_rd_addr_1),
      .mem_rd_data_0      (mem_rd_data_0),
      .mem_rd_data_1      (mem_rd_data_1),
      .lane_data_out_0    (lane_data_out_0),
      .lane_data_out_1    (lane_data_out_1),
      .lane_valid_out_0   (lane_valid_out_0),
      .lane_valid_out_1   (lane_valid_out_1),
      .rd_dest_out        (rd_dest_out),
      .col_size_out       (col_size_out),
      .col_size_valid_out (col_size_valid_out),
      .busy               (busy),
      .done               (done),
      .err                (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UB storage model: mem[i] = i + 100, synchronous read.
   logic [15:0] mem [0:127];
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'(i + 100);
   end
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data_0 <= mem[mem_rd_addr_0[6:0]];
         mem_rd_data_1 <= mem[mem_rd_addr_1[6:0]];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int busy_lo  = 0;
   int busy_hi  = -1;

   ev_t q_addr[$];
   ev_t q_l0[$];
   ev_t q_l1[$];
   ev_t q_done[$];
   ev_t q_csv[$];
   ev_t q_err[$];

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic bit model_busy(int c);
      return (c >= busy_lo) && (c <= busy_hi);
   endfunction

   // Row-major element location modulo the buffer depth.
   function automatic int elem(int base, int cols, int r, int c);
      return (base + r * cols + c) % 128;
   endfunction

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic issue(input int base, input int rows, input int cols, input bit tr, input int ptr);
      int  e0;
      int  n;
      int  m;
      int  d;
      int  a0;
      int  a1;
      bit  legal;
      rd_addr_in       = 16'(base);
      rd_row_size_in   = 16'(rows);
      rd_col_size_in   = 16'(cols);
      rd_transpose_in  = tr;
      rd_ptr_select_in = 9'(ptr);
      rd_start_in      = 1'b1;
      e0 = cyc + 1;
      n  = tr ? cols : rows;
      m  = tr ? rows : cols;
      legal = (n > 0) && (m >= 1) && (m <= 2) && (ptr <= 4) && !model_busy(cyc);
      if (legal) begin
         d = e0 + n + ((SKEW == 1 && m == 2) ? 3 : 2);
         busy_lo = e0;
         busy_hi = d;
         q_csv.push_back('{e0, n, ptr});
         for (int t = 0; t < n; t++) begin
            a0 = tr ? elem(base, cols, 0, t) : elem(base, cols, t, 0);
            a1 = tr ? elem(base, cols, 1, t) : elem(base, cols, t, 1);
            q_addr.push_back('{e0 + t, a0, (m == 2) ? a1 : -1});
            q_l0.push_back('{e0 + t + 2, a0 + 100, 0});
            if (m == 2) q_l1.push_back('{e0 + t + 2 + SKEW, a1 + 100, 0});
         end
         q_done.push_back('{d, (m == 1) ? 1 : 0, ptr});
      end else begin
         q_err.push_back('{e0, 0, 0});
      end
      $display("[cyc %0d] start base=%0d rows=%0d cols=%0d tr=%0d ptr=%0d -> %s",
               e0, base, rows, cols, tr, ptr, legal ? "accept" : "reject");
      @(negedge clk);
      rd_start_in = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
      chk({tag, "_addr0"}, int'(mem_rd_addr_0), 0);
      chk({tag, "_addr1"}, int'(mem_rd_addr_1), 0);
      chk({tag, "_lane0_data"}, int'(lane_data_out_0), 0);
      chk({tag, "_lane1_data"}, int'(lane_data_out_1), 0);
      chk({tag, "_lane0_valid"}, int'(lane_valid_out_0), 0);
      chk({tag, "_lane1_valid"}, int'(lane_valid_out_1), 0);
      chk({tag, "_dest"}, int'(rd_dest_out), 0);
      chk({tag, "_col_size"}, int'(col_size_out), 0);
      chk({tag, "_csv"}, int'(col_size_valid_out), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an output event.
   ev_t mev;
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", int'(busy), int'(model_busy(cyc)));
         if (mem_rd_en) begin
            if (q_addr.size() == 0) chk("rd_en_spurious", 1, 0);
            else begin
               mev = q_addr.pop_front();
               chk("rd_en_cycle", cyc, mev.cyc);
               chk("addr0", int'(mem_rd_addr_0), mev.a);
               if (mev.b >= 0) chk("addr1", int'(mem_rd_addr_1), mev.b);
            end
         end
         if (lane_valid_out_0) begin
            if (q_l0.size() == 0) chk("lane0_spurious", 1, 0);
            else begin
               mev = q_l0.pop_front();
               chk("lane0_cycle", cyc, mev.cyc);
               chk("lane0_data", int'(lane_data_out_0), mev.a);
            end
         end
         if (lane_valid_out_1) begin
            if (q_l1.size() == 0) chk("lane1_spurious", 1, 0);
            else begin
               mev = q_l1.pop_front();
               chk("lane1_cycle", cyc, mev.cyc);
               chk("lane1_data", int'(lane_data_out_1), mev.a);
            end
         end
         if (col_size_valid_out) begin
            if (q_csv.size() == 0) chk("csv_spurious", 1, 0);
            else begin
               mev = q_csv.pop_front();
               chk("csv_cycle", cyc, mev.cyc);
               chk("col_size_out", int'(col_size_out), mev.a);
               chk("dest_out", int'(rd_dest_out), mev.b);
            end
         end
         if (done) begin
            if (q_done.size() == 0) chk("done_spurious", 1, 0);
            else begin
               mev = q_done.pop_front();
               chk("done_cycle", cyc, mev.cyc);
               chk("dest_held", int'(rd_dest_out), mev.b);
               if (mev.a == 1) chk("lane1_inactive_zero", int'(lane_data_out_1), 0);
            end
         end
         if (err) begin
            if (q_err.size() == 0) chk("err_spurious", 1, 0);
            else begin
               mev = q_err.pop_front();
               chk("err_cycle", cyc, mev.cyc);
            end
         end
      end
   end

   initial begin
      int r;
      int n;
      int m;
      int base;
      int ptr;
      bit tr;
      rst              = 1'b1;
      rd_start_in      = 1'b0;
      rd_transpose_in  = 1'b0;
      rd_ptr_select_in = 9'd0;
      rd_addr_in       = 16'd0;
      rd_row_size_in   = 16'd0;
      rd_col_size_in   = 16'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      idle(2);

      issue(4, 3, 2, 1'b0, 0);      idle(8);
      issue(10, 2, 3, 1'b1, 1);     idle(8);
      issue(126, 2, 2, 1'b0, 2);    idle(8);
      issue(40, 2, 1, 1'b0, 3);     idle(8);
      issue(0, 3, 3, 1'b0, 0);      idle(2);
      issue(0, 2, 2, 1'b0, 7);      idle(2);
      issue(50, 4, 2, 1'b0, 4);     idle(1);
      issue(60, 2, 2, 1'b0, 0);     idle(10);

      // Start landing in the done cycle is refused; the next cycle is accepted.
      issue(70, 2, 2, 1'b0, 1);     idle(2 + ((SKEW == 1) ? 3 : 2));
      issue(80, 2, 2, 1'b0, 2);
      issue(90, 2, 2, 1'b0, 3);     idle(10);

      // Asynchronous reset in the middle of the issue phase.
      issue(20, 4, 2, 1'b0, 1);     idle(1);
      #2 rst = 1'b1;
      #1 check_zero("rst_mid");
      q_addr.delete(); q_l0.delete(); q_l1.delete();
      q_done.delete(); q_csv.delete(); q_err.delete();
      busy_hi = -1;
      idle(2);
      rst = 1'b0;
      issue(30, 2, 3, 1'b1, 2);     idle(10);

      for (int i = 0; i < 40; i++) begin
         r    = $urandom_range(0, 9);
         n    = $urandom_range(1, 6);
         m    = $urandom_range(1, 2);
         tr   = 1'($urandom_range(0, 1));
         base = (r == 0) ? $urandom_range(120, 127) : $urandom_range(0, 65535);
         ptr  = (r == 1) ? $urandom_range(5, 511) : $urandom_range(0, 4);
         if (r == 2) m = (i % 2 == 1) ? 0 : 3;
         if (r == 3) n = 0;
         issue(base, tr ? m : n, tr ? n : m, tr, ptr);
         idle($urandom_range(0, 9));
      end

      for (int i = 0; i < 100 && busy_hi >= cyc; i++) @(negedge clk);
      idle(3);
      chk("left_addr", q_addr.size(), 0);
      chk("left_lane0", q_l0.size(), 0);
      chk("left_lane1", q_l1.size(), 0);
      chk("left_done", q_done.size(), 0);
      chk("left_csv", q_csv.size(), 0);
      chk("left_err", q_err.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
